writeback_fwd: RTL

//  Parametrised writeback stage with a DEPTH-entry forwarding history. Selects ALU/load result,

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fwd_match.sv | 27 ++
 rtl/writeback_fwd.sv | 110 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared opcode encodings and helpers for the writeback/forwarding stage.
package wb_pkg;

  localparam logic [2:0] OP_SW = 3'b100;
  localparam logic [2:0] OP_LW = 3'b101;
  localparam logic [2:0] OP_BR = 3'b110;

  // Stores and branches retire without touching the register file.
  function automatic logic writes_rf(input logic [2:0] op);
    return (op != OP_SW) && (op != OP_BR);
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding lookup port: priority match of an address against the history.
module wb_fwd_match #(
  parameter int DW    = 16,
  parameter int RW    = 3,
  parameter int DEPTH = 2
) (
  input  logic [RW-1:0]                addr_i,
  input  logic [DEPTH-1:0]             ent_vld_i,
  input  logic [DEPTH-1:0][RW-1:0]     ent_tgt_i,
  input  logic [DEPTH-1:0][DW-1:0]     ent_data_i,
  output logic                         hit_o,
  output logic [DW-1:0]                data_o
);

  // Scan oldest to newest so the lowest-index (newest) match overrides.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_vld_i[k] && (ent_tgt_i[k] == addr_i) && (addr_i != '0)) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[k];
      end
    end
  end

endmodule

// File: rtl/writeback_fwd.sv
// Writeback stage with a DEPTH-entry forwarding history and NUM_RD bypass ports.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_fwd
  import wb_pkg::*;
#(
  parameter int DW     = 16,
  parameter int RW     = 3,
  parameter int DEPTH  = 2,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     halt,
  input  logic                     flush,
  input  logic                     bubble_in,
  input  logic [RW-1:0]            tgt_in,
  input  logic [2:0]               opcode_in,
  input  logic [DW-1:0]            alu_result,
  input  logic [DW-1:0]            mem_result,
  output logic [DW-1:0]            result_out,
  output logic                     we,
  output logic [RW-1:0]            wb_tgt_out,
  output logic [DW-1:0]            wb_result_out,
  input  logic [NUM_RD*RW-1:0]     rd_addr,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic [NUM_RD*DW-1:0]     fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]         retire_cnt
`endif
);

  if (DEPTH < 1 || NUM_RD < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("writeback_fwd: DEPTH, NUM_RD and CNT_W must be >= 1");
  end

  // Entry layout depends on DW/RW, so the struct lives here rather than in wb_pkg.
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] tgt;
    logic [DW-1:0] data;
  } hist_entry_t;

  hist_entry_t [DEPTH-1:0] hist_q, hist_d;

  logic [DEPTH-1:0]         ent_vld;
  logic [DEPTH-1:0][RW-1:0] ent_tgt;
  logic [DEPTH-1:0][DW-1:0] ent_data;

  assign we         = (tgt_in != '0) && writes_rf(opcode_in) && !bubble_in;
  assign result_out = (opcode_in == OP_LW) ? mem_result : alu_result;

  // Flush clears pre-existing entries first; the shift then still commits this slot.
  always_comb begin
    hist_d = hist_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) hist_d[k].valid = 1'b0;
    end
    if (!halt) begin
      for (int k = DEPTH - 1; k > 0; k--) hist_d[k] = hist_d[k-1];
      hist_d[0].valid = we;
      hist_d[0].tgt   = tgt_in;
      hist_d[0].data  = result_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= hist_d;
  end

  assign wb_tgt_out    = hist_q[0].valid ? hist_q[0].tgt : '0;
  assign wb_result_out = hist_q[0].data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    assign ent_vld[k]  = hist_q[k].valid;
    assign ent_tgt[k]  = hist_q[k].tgt;
    assign ent_data[k] = hist_q[k].data;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    wb_fwd_match #(
      .DW    (DW),
      .RW    (RW),
      .DEPTH (DEPTH)
    ) u_match (
      .addr_i     (rd_addr[i*RW +: RW]),
      .ent_vld_i  (ent_vld),
      .ent_tgt_i  (ent_tgt),
      .ent_data_i (ent_data),
      .hit_o      (fwd_hit[i]),
      .data_o     (fwd_data[i*DW +: DW])
    );
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = (!halt && !bubble_in) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`endif

endmodule
